// File: rtl/field_move_sched_if.sv
// Bundle of the load port, the per-requester move requests and the engine status
// for field_move_sched. Master = control agents, slave = the scheduler.
interface field_move_sched_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
);
    logic              load_valid_i;
    logic [31:0]       load_data_i;
    logic              load_ready_o;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ*5-1:0] req_src_i;
    logic [NREQ*5-1:0] req_dst_i;
    logic [NREQ*5-1:0] req_len_i;
    logic [NREQ-1:0]   req_ack_o;
    logic              busy_o;
    logic [IDXW-1:0]   gnt_idx_o;
    logic [31:0]       word_o;

    modport master (
        output load_valid_i, load_data_i, req_valid_i, req_src_i, req_dst_i, req_len_i,
        input  load_ready_o, req_ack_o, busy_o, gnt_idx_o, word_o
    );

    modport slave (
        input  load_valid_i, load_data_i, req_valid_i, req_src_i, req_dst_i, req_len_i,
        output load_ready_o, req_ack_o, busy_o, gnt_idx_o, word_o
    );
endinterface

// File: rtl/field_move_sched.sv
// Round-robin scheduler for a shared bit-field copy engine working on one 32-bit word.
// Sequence per request: grant in IDLE, move in EXEC, one-cycle ack in DONE.
module field_move_sched #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    field_move_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     word_q;
    logic [IDXW-1:0] ptr_q, idx_q;
    logic [4:0]      src_q, dst_q, len_q;

    logic            gnt_found;
    logic [IDXW-1:0] gnt_sel;
    logic [31:0]     len_mask, field, moved;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        int cand;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        gnt_found = 1'b0;
        gnt_sel   = '0;
        cand      = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(ptr_q) + off) % NREQ;
            if (!gnt_found && bus.req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_sel   = IDXW'(cand);
            end
        end
    end

    // Logical shifts zero-fill source bits above 31 and drop destination bits above 31.
    always_comb begin
        len_mask = 32'hFFFF_FFFF >> (5'd31 - len_q);
        field    = (word_q >> src_q) & len_mask;
        moved    = (word_q & ~(len_mask << dst_q)) | (field << dst_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.load_valid_i && gnt_found) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            ptr_q  <= IDXW'(NREQ - 1);
            idx_q  <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_valid_i) begin
                        word_q <= bus.load_data_i;
                    end else if (gnt_found) begin
                        idx_q <= gnt_sel;
                        ptr_q <= gnt_sel;
                        src_q <= bus.req_src_i[5*int'(gnt_sel) +: 5];
                        dst_q <= bus.req_dst_i[5*int'(gnt_sel) +: 5];
                        len_q <= bus.req_len_i[5*int'(gnt_sel) +: 5];
                    end
                end
                EXEC:    word_q <= moved;
                default: ;
            endcase
        end
    end

    assign bus.load_ready_o = (state_q == IDLE);
    assign bus.busy_o       = (state_q == EXEC) || (state_q == DONE);
    assign bus.req_ack_o    = (state_q == DONE) ? (NREQ'(1) << idx_q) : '0;
    assign bus.gnt_idx_o    = idx_q;
    assign bus.word_o       = word_q;
endmodule

// File: tb/tb_field_move_sched.sv
// Self-checking bench for field_move_sched: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_field_move_sched;
    localparam int NREQ = 4;
    localparam int IDXW = 3;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    bit   chk_on = 1'b0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_n++;

    field_move_sched_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();

    field_move_sched #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 move pending, 2 acknowledging.
    int          m_phase, m_ptr, m_idx, m_src, m_dst, m_len;
    logic [31:0] m_word;

    function automatic logic [31:0] m_move(input logic [31:0] w, input int s, input int d, input int l);
        logic [31:0] r;
        r = w;
        for (int i = 0; i <= l; i++)
            if (d + i < 32) r[d+i] = (s + i < 32) ? w[s+i] : 1'b0;
        return r;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase = 0; m_ptr = NREQ - 1; m_idx = 0; m_word = '0;
            m_src = 0; m_dst = 0; m_len = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.load_valid_i) begin
                        m_word = bus.load_data_i;
                    end else begin
                        for (int off = 1; off <= NREQ && m_phase == 0; off++) begin
                            int c;
                            c = (m_ptr + off) % NREQ;
                            if (bus.req_valid_i[c]) begin
                                m_src = int'(bus.req_src_i[5*c +: 5]);
                                m_dst = int'(bus.req_dst_i[5*c +: 5]);
                                m_len = int'(bus.req_len_i[5*c +: 5]);
                                m_idx = c; m_ptr = c; m_phase = 1;
                            end
                        end
                    end
                end
                1: begin m_word = m_move(m_word, m_src, m_dst, m_len); m_phase = 2; end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (chk_on && rst_ni) begin
            check("load_ready", 32'(bus.load_ready_o), 32'(m_phase == 0));
            check("busy", 32'(bus.busy_o), 32'(m_phase != 0));
            check("ack", 32'(bus.req_ack_o), (m_phase == 2) ? (32'd1 << m_idx) : 32'd0);
            check("gnt_idx", 32'(bus.gnt_idx_o), 32'(m_idx));
            check("word", bus.word_o, m_word);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.load_valid_i = 1'b0;
        bus.load_data_i  = '0;
        bus.req_valid_i  = '0;
        bus.req_src_i    = '0;
        bus.req_dst_i    = '0;
        bus.req_len_i    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic load_word(input logic [31:0] w);
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = w;
        tick();
        bus.load_valid_i = 1'b0;
        check("load_word", bus.word_o, w);
    endtask

    task automatic set_ops(input int k, input int s, input int d, input int l);
        bus.req_src_i[5*k +: 5] = 5'(s);
        bus.req_dst_i[5*k +: 5] = 5'(d);
        bus.req_len_i[5*k +: 5] = 5'(l);
    endtask

    // Single requester move; operands are scrambled after grant to show they were latched.
    task automatic do_move(input int k, input int s, input int d, input int l, input logic [31:0] exp);
        set_ops(k, s, d, l);
        bus.req_valid_i[k] = 1'b1;
        tick();
        bus.req_valid_i[k] = 1'b0;
        set_ops(k, 31 - s, 31 - d, 31 - l);
        check("grant_idx", 32'(bus.gnt_idx_o), 32'(k));
        check("grant_ack_low", 32'(bus.req_ack_o), 32'd0);
        tick();
        check("move_ack", 32'(bus.req_ack_o), 32'd1 << k);
        check("move_word", bus.word_o, exp);
        tick();
        check("ack_one_cycle", 32'(bus.req_ack_o), 32'd0);
        check("ready_again", 32'(bus.load_ready_o), 32'd1);
    endtask

    task automatic wait_ack(output int idx, output int cyc);
        bit seen;
        seen = 1'b0;
        idx = -1;
        cyc = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.req_ack_o != '0) begin
                seen = 1'b1;
                cyc = cyc_n;
                for (int i = 0; i < NREQ; i++) if (bus.req_ack_o[i]) idx = i;
            end
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_order(input logic [NREQ-1:0] start_valid, input logic [NREQ-1:0] after_first,
                             input int exp0, input int exp1, input int exp2, input int exp3, input int exp4);
        int exp_q[5];
        int idx, cyc, prev;
        exp_q = '{exp0, exp1, exp2, exp3, exp4};
        prev = 0;
        bus.req_valid_i = start_valid;
        for (int i = 0; i < 5; i++) begin
            wait_ack(idx, cyc);
            check("rr_order", 32'(idx), 32'(exp_q[i]));
            if (i > 0) check("rr_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
            if (i == 0) bus.req_valid_i = after_first;
        end
        bus.req_valid_i = '0;
    endtask

    initial begin
        clear_inputs();
        do_reset();
        chk_on = 1'b1;
        check("rst_word", bus.word_o, 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_ready", 32'(bus.load_ready_o), 32'd1);
        check("rst_gnt", 32'(bus.gnt_idx_o), 32'd0);

        // Basic move, destination overflow, source zero-fill.
        load_word(32'h0000_00AB);
        do_move(0, 0, 24, 7, 32'hAB00_00AB);
        load_word(32'h0000_00AB);
        do_move(1, 0, 28, 7, 32'hB000_00AB);
        load_word(32'hF000_0000);
        do_move(2, 28, 0, 7, 32'hF000_000F);
        load_word(32'h1234_5678);
        do_move(3, 9, 9, 12, 32'h1234_5678);
        do_move(1, 0, 0, 31, 32'h1234_5678);

        // All requesters hold valid: strict rotation from req0.
        do_reset();
        run_order(4'b1111, 4'b1111, 0, 1, 2, 3, 0);
        // req3 joins at the first ack and is reached after req1.
        do_reset();
        run_order(4'b0011, 4'b1011, 0, 1, 3, 0, 1);
        tick(); tick(); tick();

        // Load beats a simultaneous request; load during EXEC/DONE is ignored.
        do_reset();
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 32'h1234_5678;
        set_ops(0, 0, 8, 7);
        bus.req_valid_i[0] = 1'b1;
        tick();
        check("load_wins_word", bus.word_o, 32'h1234_5678);
        check("load_wins_busy", 32'(bus.busy_o), 32'd0);
        bus.load_valid_i = 1'b0;
        tick();
        bus.req_valid_i[0] = 1'b0;
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 32'hDEAD_BEEF;
        check("exec_ready_low", 32'(bus.load_ready_o), 32'd0);
        tick();
        check("move_on_new_word", bus.word_o, 32'h1234_7878);
        tick();
        bus.load_valid_i = 1'b0;
        check("exec_load_ignored", bus.word_o, 32'h1234_7878);

        // Asynchronous reset during EXEC aborts without ack.
        load_word(32'hCAFE_0001);
        set_ops(0, 0, 4, 3);
        bus.req_valid_i[0] = 1'b1;
        tick();
        bus.req_valid_i[0] = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("abort_word", bus.word_o, 32'd0);
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_ack", 32'(bus.req_ack_o), 32'd0);
        tick();
        check("abort_no_ack", 32'(bus.req_ack_o), 32'd0);
        rst_ni = 1'b1;
        bus.req_valid_i = 4'b1111;
        tick();
        check("post_rst_gnt", 32'(bus.gnt_idx_o), 32'd0);
        bus.req_valid_i = '0;
        tick(); tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bus.load_valid_i = ($urandom_range(0, 7) == 0);
            bus.load_data_i  = $urandom;
            bus.req_valid_i  = NREQ'($urandom);
            bus.req_src_i    = (NREQ*5)'({$urandom, $urandom});
            bus.req_dst_i    = (NREQ*5)'({$urandom, $urandom});
            bus.req_len_i    = (NREQ*5)'({$urandom, $urandom});
            if ($urandom_range(0, 15) == 0) bus.req_dst_i = bus.req_src_i;
            tick();
        end
        clear_inputs();
        tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
